// File: rtl/ycbcr_skin_bbox.sv
// rtl/ycbcr_skin_bbox.sv - Cb/Cr skin classifier with per-frame bounding box and pixel count
module ycbcr_skin_bbox #(
  parameter int DSIZE  = 10,
  parameter int IMG_W  = 640,
  parameter int IMG_H  = 480,
  parameter int XW     = 11,
  parameter int YW     = 10,
  parameter int CW     = 20,
  parameter int CB_MIN = 308,
  parameter int CB_MAX = 508,
  parameter int CR_MIN = 532,
  parameter int CR_MAX = 692
) (
  input  logic             clock,
  input  logic             rst_n,
  input  logic [DSIZE-1:0] inY,
  input  logic [DSIZE-1:0] inCb,
  input  logic [DSIZE-1:0] inCr,
  input  logic             ien,
  input  logic             in_vs,
  output logic             obin,
  output logic [DSIZE-1:0] oY,
  output logic             oen,
  output logic [XW-1:0]    x_min,
  output logic [XW-1:0]    x_max,
  output logic [YW-1:0]    y_min,
  output logic [YW-1:0]    y_max,
  output logic [CW-1:0]    pix_cnt,
  output logic             obj_found,
  output logic             frame_done
);

  localparam logic [DSIZE-1:0] CB_LO  = DSIZE'(CB_MIN);
  localparam logic [DSIZE-1:0] CB_HI  = DSIZE'(CB_MAX);
  localparam logic [DSIZE-1:0] CR_LO  = DSIZE'(CR_MIN);
  localparam logic [DSIZE-1:0] CR_HI  = DSIZE'(CR_MAX);
  localparam logic [XW-1:0]    X_LAST = XW'(IMG_W - 1);
  localparam logic [YW-1:0]    Y_LAST = YW'(IMG_H - 1);
  localparam logic [XW-1:0]    X_ONES = '1;
  localparam logic [YW-1:0]    Y_ONES = '1;
  localparam logic [CW-1:0]    C_MAX  = '1;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_ACTIVE = 2'd1,
    S_DONE   = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic             vs_d_q, vs_d_d;
  logic [XW-1:0]    x_q, x_d;
  logic [YW-1:0]    y_q, y_d;
  logic [XW-1:0]    xmin_acc_q, xmin_acc_d;
  logic [XW-1:0]    xmax_acc_q, xmax_acc_d;
  logic [YW-1:0]    ymin_acc_q, ymin_acc_d;
  logic [YW-1:0]    ymax_acc_q, ymax_acc_d;
  logic [CW-1:0]    cnt_acc_q, cnt_acc_d;
  logic             obin_q, obin_d;
  logic [DSIZE-1:0] oy_q, oy_d;
  logic             oen_q, oen_d;
  logic [XW-1:0]    x_min_q, x_min_d;
  logic [XW-1:0]    x_max_q, x_max_d;
  logic [YW-1:0]    y_min_q, y_min_d;
  logic [YW-1:0]    y_max_q, y_max_d;
  logic [CW-1:0]    pix_cnt_q, pix_cnt_d;
  logic             obj_found_q, obj_found_d;
  logic             frame_done_q, frame_done_d;

  logic             vs_rise;
  logic             skin;
  logic             take;
  logic [XW-1:0]    cur_x;
  logic [YW-1:0]    cur_y;

  assign vs_rise = in_vs & ~vs_d_q;
  assign skin    = (inCb >= CB_LO) && (inCb <= CB_HI) &&
                   (inCr >= CR_LO) && (inCr <= CR_HI);

  // Pixel path: one-register delay for mask, luma and valid; mask forced low on bubbles
  always_comb begin
    oen_d  = ien;
    obin_d = ien & skin;
    oy_d   = inY;
  end

  // Frame FSM next state, position counters, accumulators and publication
  always_comb begin
    state_d      = state_q;
    vs_d_d       = in_vs;
    x_d          = x_q;
    y_d          = y_q;
    xmin_acc_d   = xmin_acc_q;
    xmax_acc_d   = xmax_acc_q;
    ymin_acc_d   = ymin_acc_q;
    ymax_acc_d   = ymax_acc_q;
    cnt_acc_d    = cnt_acc_q;
    x_min_d      = x_min_q;
    x_max_d      = x_max_q;
    y_min_d      = y_min_q;
    y_max_d      = y_max_q;
    pix_cnt_d    = pix_cnt_q;
    obj_found_d  = obj_found_q;
    frame_done_d = 1'b0;
    take         = 1'b0;
    cur_x        = x_q;
    cur_y        = y_q;

    if (vs_rise) begin
      // A new frame start overrides everything, including a pending publish,
      // and a coincident pixel becomes (0,0) of the new frame.
      state_d    = S_ACTIVE;
      cur_x      = '0;
      cur_y      = '0;
      x_d        = '0;
      y_d        = '0;
      xmin_acc_d = X_ONES;
      xmax_acc_d = '0;
      ymin_acc_d = Y_ONES;
      ymax_acc_d = '0;
      cnt_acc_d  = '0;
      take       = ien;
    end else begin
      case (state_q)
        S_ACTIVE: take = ien;
        S_DONE: begin
          state_d      = S_IDLE;
          frame_done_d = 1'b1;
          if (cnt_acc_q != '0) begin
            x_min_d     = xmin_acc_q;
            x_max_d     = xmax_acc_q;
            y_min_d     = ymin_acc_q;
            y_max_d     = ymax_acc_q;
            pix_cnt_d   = cnt_acc_q;
            obj_found_d = 1'b1;
          end else begin
            x_min_d     = '0;
            x_max_d     = '0;
            y_min_d     = '0;
            y_max_d     = '0;
            pix_cnt_d   = '0;
            obj_found_d = 1'b0;
          end
        end
        default: ;
      endcase
    end

    if (take) begin
      if (cur_x == X_LAST) begin
        x_d = '0;
        if (cur_y == Y_LAST) begin
          y_d     = '0;
          state_d = S_DONE;
        end else begin
          y_d = cur_y + 1'b1;
        end
      end else begin
        x_d = cur_x + 1'b1;
      end

      if (skin) begin
        if (cur_x < xmin_acc_d) xmin_acc_d = cur_x;
        if (cur_x > xmax_acc_d) xmax_acc_d = cur_x;
        if (cur_y < ymin_acc_d) ymin_acc_d = cur_y;
        if (cur_y > ymax_acc_d) ymax_acc_d = cur_y;
        if (cnt_acc_d != C_MAX) cnt_acc_d = cnt_acc_d + 1'b1;
      end
    end
  end

  // State and datapath registers with asynchronous clear
  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= S_IDLE;
      vs_d_q       <= 1'b0;
      x_q          <= '0;
      y_q          <= '0;
      xmin_acc_q   <= X_ONES;
      xmax_acc_q   <= '0;
      ymin_acc_q   <= Y_ONES;
      ymax_acc_q   <= '0;
      cnt_acc_q    <= '0;
      obin_q       <= 1'b0;
      oy_q         <= '0;
      oen_q        <= 1'b0;
      x_min_q      <= '0;
      x_max_q      <= '0;
      y_min_q      <= '0;
      y_max_q      <= '0;
      pix_cnt_q    <= '0;
      obj_found_q  <= 1'b0;
      frame_done_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      vs_d_q       <= vs_d_d;
      x_q          <= x_d;
      y_q          <= y_d;
      xmin_acc_q   <= xmin_acc_d;
      xmax_acc_q   <= xmax_acc_d;
      ymin_acc_q   <= ymin_acc_d;
      ymax_acc_q   <= ymax_acc_d;
      cnt_acc_q    <= cnt_acc_d;
      obin_q       <= obin_d;
      oy_q         <= oy_d;
      oen_q        <= oen_d;
      x_min_q      <= x_min_d;
      x_max_q      <= x_max_d;
      y_min_q      <= y_min_d;
      y_max_q      <= y_max_d;
      pix_cnt_q    <= pix_cnt_d;
      obj_found_q  <= obj_found_d;
      frame_done_q <= frame_done_d;
    end
  end

  assign obin       = obin_q;
  assign oY         = oy_q;
  assign oen        = oen_q;
  assign x_min      = x_min_q;
  assign x_max      = x_max_q;
  assign y_min      = y_min_q;
  assign y_max      = y_max_q;
  assign pix_cnt    = pix_cnt_q;
  assign obj_found  = obj_found_q;
  assign frame_done = frame_done_q;

endmodule

// File: tb/tb_ycbcr_skin_bbox.sv
// tb/tb_ycbcr_skin_bbox.sv - randomized self-checking bench for ycbcr_skin_bbox
module tb_ycbcr_skin_bbox;

  localparam int W    = 8;
  localparam int H    = 4;
  localparam int NPIX = W * H;

  logic        clock = 1'b0;
  logic        rst_n = 1'b0;
  logic [9:0]  inY   = '0;
  logic [9:0]  inCb  = '0;
  logic [9:0]  inCr  = '0;
  logic        ien   = 1'b0;
  logic        in_vs = 1'b0;
  logic        obin;
  logic [9:0]  oY;
  logic        oen;
  logic [10:0] x_min, x_max;
  logic [9:0]  y_min, y_max;
  logic [19:0] pix_cnt;
  logic        obj_found;
  logic        frame_done;

  always #5 clock = ~clock;

  ycbcr_skin_bbox #(.IMG_W(W), .IMG_H(H)) dut (
    .clock(clock), .rst_n(rst_n), .inY(inY), .inCb(inCb), .inCr(inCr),
    .ien(ien), .in_vs(in_vs), .obin(obin), .oY(oY), .oen(oen),
    .x_min(x_min), .x_max(x_max), .y_min(y_min), .y_max(y_max),
    .pix_cnt(pix_cnt), .obj_found(obj_found), .frame_done(frame_done)
  );

  int tests = 0;
  int fails = 0;
  int done_seen = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  bit m_vs_prev, m_in_frame, m_pend, m_oen, m_obin, m_done;
  int m_oy, m_idx;
  int f_cnt, f_xmin, f_xmax, f_ymin, f_ymax;
  int p_xmin, p_xmax, p_ymin, p_ymax, p_cnt, p_obj;

  function automatic bit is_skin(int cb, int cr);
    return (cb >= 308) && (cb <= 508) && (cr >= 532) && (cr <= 692);
  endfunction

  function automatic void model_reset();
    m_vs_prev = 0; m_in_frame = 0; m_pend = 0;
    m_oen = 0; m_obin = 0; m_done = 0; m_oy = 0; m_idx = 0;
    f_cnt = 0; f_xmin = 0; f_xmax = 0; f_ymin = 0; f_ymax = 0;
    p_xmin = 0; p_xmax = 0; p_ymin = 0; p_ymax = 0; p_cnt = 0; p_obj = 0;
  endfunction

  function automatic void model_step();
    bit rise;
    bit sk;
    int px, py;
    rise = in_vs && !m_vs_prev;
    m_vs_prev = in_vs;
    m_done = 0;
    if (rise) begin
      m_in_frame = 1; m_idx = 0; m_pend = 0; f_cnt = 0;
    end else if (m_pend) begin
      m_pend = 0;
      m_done = 1;
      if (f_cnt > 0) begin
        p_xmin = f_xmin; p_xmax = f_xmax; p_ymin = f_ymin; p_ymax = f_ymax;
        p_cnt = f_cnt; p_obj = 1;
      end else begin
        p_xmin = 0; p_xmax = 0; p_ymin = 0; p_ymax = 0; p_cnt = 0; p_obj = 0;
      end
    end
    sk     = is_skin(int'(inCb), int'(inCr));
    m_oen  = ien;
    m_obin = ien && sk;
    m_oy   = int'(inY);
    if (m_in_frame && ien) begin
      px = m_idx % W;
      py = m_idx / W;
      if (sk) begin
        if (f_cnt == 0) begin
          f_xmin = px; f_xmax = px; f_ymin = py; f_ymax = py;
        end else begin
          if (px < f_xmin) f_xmin = px;
          if (px > f_xmax) f_xmax = px;
          if (py < f_ymin) f_ymin = py;
          if (py > f_ymax) f_ymax = py;
        end
        f_cnt++;
      end
      m_idx++;
      if (m_idx == NPIX) begin
        m_in_frame = 0;
        m_pend = 1;
      end
    end
  endfunction

  // Advance the model on every active edge
  initial forever begin
    @(posedge clock);
    if (!rst_n) model_reset();
    else model_step();
  end

  // Compare DUT outputs against the model every cycle, away from the edge
  initial forever begin
    @(negedge clock);
    if (!rst_n) model_reset();
    chk("oen", oen, m_oen);
    if (m_oen) begin
      chk("obin", obin, m_obin);
      chk("oY", oY, m_oy);
    end
    chk("frame_done", frame_done, m_done);
    chk("x_min", x_min, p_xmin);
    chk("x_max", x_max, p_xmax);
    chk("y_min", y_min, p_ymin);
    chk("y_max", y_max, p_ymax);
    chk("pix_cnt", pix_cnt, p_cnt);
    chk("obj_found", obj_found, p_obj);
    if (frame_done === 1'b1) done_seen++;
  end

  initial begin
    #300000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  // ---------------- stimulus ----------------
  int cb_a[NPIX];
  int cr_a[NPIX];

  function automatic int rnd();
    return int'($urandom_range(0, 1023));
  endfunction

  task automatic px(input bit en, input int cb, input int cr, input int yv, input bit vs);
    ien   = en;
    inCb  = 10'(cb);
    inCr  = 10'(cr);
    inY   = 10'(yv);
    in_vs = vs;
    @(posedge clock);
    #2;
  endtask

  task automatic idle(input int n);
    repeat (n) px(0, rnd(), rnd(), rnd(), 0);
  endtask

  task automatic fill_nonskin();
    for (int i = 0; i < NPIX; i++) begin
      cb_a[i] = 100;
      cr_a[i] = 100;
    end
  endtask

  task automatic fill_random();
    for (int i = 0; i < NPIX; i++) begin
      cb_a[i] = int'($urandom_range(290, 530));
      cr_a[i] = int'($urandom_range(510, 710));
    end
  endtask

  task automatic run_frame(input int gap_max, input bit vs_first);
    bit vs_lvl;
    if (!vs_first) px(0, rnd(), rnd(), rnd(), 1);
    for (int i = 0; i < NPIX; i++) begin
      vs_lvl = vs_first ? (i < 2) : (i < 1);
      if (gap_max > 0 && i > 0)
        repeat ($urandom_range(0, gap_max)) px(0, rnd(), rnd(), rnd(), vs_lvl);
      px(1, cb_a[i], cr_a[i], rnd(), vs_lvl);
    end
    ien   = 1'b0;
    in_vs = 1'b0;
  endtask

  int tcb[6] = '{308, 508, 307, 508, 509, 400};
  int tcr[6] = '{532, 692, 532, 693, 600, 531};
  bit tbin[6] = '{1, 1, 0, 0, 0, 0};
  int d0;
  int sv_xmin, sv_xmax, sv_ymin, sv_ymax, sv_cnt, sv_obj;

  initial begin
    // Reset held with live random input
    @(posedge clock); #2;
    repeat (4) px(1, rnd(), rnd(), rnd(), $urandom_range(0, 1) == 1);
    px(1, 400, 600, rnd(), 0);
    chk("rst_oen", oen, 0);
    chk("rst_obin", obin, 0);
    chk("rst_oY", oY, 0);
    chk("rst_pix_cnt", pix_cnt, 0);
    chk("rst_frame_done", frame_done, 0);
    rst_n = 1'b1;
    d0 = done_seen;
    idle(6);
    chk("no_done_without_vs", done_seen - d0, 0);

    // Threshold edges while idle: mask and luma still pass through
    for (int i = 0; i < 6; i++) begin
      px(1, tcb[i], tcr[i], 100 + i, 0);
      chk("thr_oen", oen, 1);
      chk("thr_obin", obin, tbin[i]);
      chk("thr_oY", oY, 100 + i);
    end
    px(0, 400, 600, 5, 0);
    chk("bubble_oen", oen, 0);

    // Sync collision: only the pixel sharing the vs edge is skin -> (0,0)
    fill_nonskin();
    cb_a[0] = 400; cr_a[0] = 600;
    run_frame(0, 1);
    @(posedge clock); #2;
    chk("col_done", frame_done, 1);
    chk("col_x_min", x_min, 0);
    chk("col_x_max", x_max, 0);
    chk("col_y_max", y_max, 0);
    chk("col_pix_cnt", pix_cnt, 1);
    chk("col_obj", obj_found, 1);
    idle(1);
    chk("col_done_pulse", frame_done, 0);

    // Bounding box from (2,1), (5,1), (3,3)
    fill_nonskin();
    cb_a[10] = 308; cr_a[10] = 532;
    cb_a[13] = 508; cr_a[13] = 692;
    cb_a[27] = 420; cr_a[27] = 610;
    run_frame(0, 0);
    chk("bb_early", frame_done, 0);
    @(posedge clock); #2;
    chk("bb_done", frame_done, 1);
    chk("bb_x_min", x_min, 2);
    chk("bb_x_max", x_max, 5);
    chk("bb_y_min", y_min, 1);
    chk("bb_y_max", y_max, 3);
    chk("bb_pix_cnt", pix_cnt, 3);
    chk("bb_obj", obj_found, 1);
    idle(3);
    chk("bb_hold", x_max, 5);

    // Empty frame replaces previous result
    fill_nonskin();
    run_frame(2, 0);
    @(posedge clock); #2;
    chk("empty_done", frame_done, 1);
    chk("empty_pix_cnt", pix_cnt, 0);
    chk("empty_obj", obj_found, 0);
    chk("empty_x_max", x_max, 0);
    chk("empty_y_max", y_max, 0);
    idle(2);

    // Abort after 10 skin pixels, then full frame with 4 corner skin pixels
    d0 = done_seen;
    for (int i = 0; i < 10; i++) px(1, 400, 600, rnd(), i < 2);
    fill_nonskin();
    cb_a[0] = 400;  cr_a[0] = 600;
    cb_a[7] = 400;  cr_a[7] = 600;
    cb_a[24] = 400; cr_a[24] = 600;
    cb_a[31] = 400; cr_a[31] = 600;
    run_frame(0, 1);
    idle(3);
    chk("abort_done_count", done_seen - d0, 1);
    chk("abort_pix_cnt", pix_cnt, 4);
    chk("abort_x_max", x_max, 7);
    chk("abort_y_max", y_max, 3);

    // Bubbles: same frame with and without gaps gives the same result
    fill_random();
    run_frame(0, 0);
    idle(2);
    sv_xmin = p_xmin; sv_xmax = p_xmax; sv_ymin = p_ymin;
    sv_ymax = p_ymax; sv_cnt = p_cnt; sv_obj = p_obj;
    run_frame(3, 0);
    idle(2);
    chk("gap_x_min", x_min, sv_xmin);
    chk("gap_x_max", x_max, sv_xmax);
    chk("gap_y_min", y_min, sv_ymin);
    chk("gap_y_max", y_max, sv_ymax);
    chk("gap_pix_cnt", pix_cnt, sv_cnt);
    chk("gap_obj", obj_found, sv_obj);

    // Random frames, random aborts, random idle pixels
    repeat (8) begin
      if ($urandom_range(0, 2) == 0)
        for (int i = 0; i < int'($urandom_range(1, 20)); i++)
          px(1, int'($urandom_range(290, 530)), int'($urandom_range(510, 710)), rnd(), i == 0);
      fill_random();
      run_frame(int'($urandom_range(0, 2)), $urandom_range(0, 1) == 1);
      repeat ($urandom_range(1, 4))
        px($urandom_range(0, 1) == 1, int'($urandom_range(290, 530)), int'($urandom_range(510, 710)), rnd(), 0);
      ien = 1'b0;
      idle(1);
    end

    // Reset mid-frame clears immediately; no frame without a new vs edge
    fill_random();
    cb_a[0] = 400; cr_a[0] = 600;
    run_frame(0, 1);
    idle(2);
    for (int i = 0; i < 12; i++) px(1, 400, 600, rnd(), i < 2);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_pix_cnt", pix_cnt, 0);
    chk("mid_rst_obj", obj_found, 0);
    chk("mid_rst_oen", oen, 0);
    @(posedge clock); #2;
    rst_n = 1'b1;
    d0 = done_seen;
    for (int i = 0; i < NPIX + 4; i++) px(1, 400, 600, rnd(), 0);
    idle(3);
    chk("mid_rst_no_done", done_seen - d0, 0);

    idle(3);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/ycbcr_skin_bbox.md
# ycbcr_skin_bbox

Skin-colour segmentation and object localisation stage that consumes the Y/Cb/Cr stream and the 3-clock-delayed enable from the RGB-to-YCbCr converter. Each pixel is classified by Cb/Cr window thresholds into a 1-bit mask forwarded downstream to morphology/recognition. Per frame, the bounding box and pixel count of all skin pixels are accumulated and published with a one-cycle done pulse for the figure-recognition controller.

## Interface
- DSIZE, 10, component width (matches converter output)
- IMG_W, 640, active pixels per line
- IMG_H, 480, active lines per frame
- XW, 11, column counter / bbox x width
- YW, 10, row counter / bbox y width
- CW, 20, skin pixel count width
- CB_MIN, 308, inclusive lower Cb bound
- CB_MAX, 508, inclusive upper Cb bound
- CR_MIN, 532, inclusive lower Cr bound
- CR_MAX, 692, inclusive upper Cr bound

Reset is `rst_n`, asynchronous, active-low; the clock is `clock`.

- clock  in  1  pixel clock
- rst_n  in  1  asynchronous active-low reset
- inY  in  DSIZE  luma (pass-through only)
- inCb  in  DSIZE  blue-difference chroma
- inCr  in  DSIZE  red-difference chroma
- ien  in  1  pixel valid (converter oen)
- in_vs  in  1  frame sync, active high; rising edge = frame start
- obin  out  1  skin mask bit, valid when oen=1
- oY  out  DSIZE  luma delayed to align with obin
- oen  out  1  output valid
- x_min, x_max  out  XW  bounding box columns of last frame
- y_min, y_max  out  YW  bounding box rows of last frame
- pix_cnt  out  CW  skin pixels in last frame
- obj_found  out  1  last frame had pix_cnt>0
- frame_done  out  1  one-cycle pulse when the above update

## Operation
- Classification: skin = (CB_MIN<=inCb<=CB_MAX) && (CR_MIN<=inCr<=CR_MAX), unsigned compares, both bounds inclusive. Y does not affect skin.
- Position counters x (0..IMG_W-1), y (0..IMG_H-1) advance on each ien=1; x wraps to 0 at IMG_W-1 and increments y.
- Frame state machine: IDLE -> ACTIVE on in_vs rising edge (edge = in_vs & ~in_vs_d, in_vs_d registered). ACTIVE -> DONE after the pixel at (IMG_W-1, IMG_H-1) is accepted. DONE -> IDLE next cycle. Any in_vs rising edge in any state forces ACTIVE with x=y=0 and clears accumulators; a frame aborted this way produces no frame_done.
- ien in IDLE (before first vs, or after a complete frame) is passed to obin/oen but not counted or accumulated.
- Accumulators (ACTIVE only, on registered skin pixel): x_min_acc=min, x_max_acc=max, y_min/y_max likewise, cnt_acc+1. Clear values: min accumulators = all ones, max = 0, cnt = 0.
- In DONE: if cnt_acc>0, copy accumulators to outputs, obj_found=1; else all bbox outputs and pix_cnt = 0, obj_found=0. frame_done=1 for that cycle only. Published outputs hold until the next DONE.
- Simultaneous in_vs rising edge and ien: the edge wins first; that pixel is counted as (0,0) of the new frame.
- cnt_acc saturates at 2^CW-1 (not reachable at default sizes).

## Timing
- Reset: obin=0, oY=0, oen=0, all bbox outputs 0, pix_cnt=0, obj_found=0, frame_done=0, state IDLE, counters 0, in_vs_d=0.
- Pixel latency 1 clk: ien at cycle t -> oen=1, obin/oY valid at t+1. Bubbles (ien=0) propagate as oen=0; no back-pressure.
- Last pixel accepted at t -> accumulators include it at t+1 -> frame_done high at t+2 with new outputs visible the same cycle.
- Reset asserted mid-frame: everything returns to reset values immediately; restart requires a new in_vs rising edge.

## Test plan
- Reset: hold rst_n=0 with ien=1 and random data -> all outputs 0; release -> no frame_done without in_vs.
- Threshold edges (IMG_W=8, IMG_H=4): Cb/Cr = 308/532, 508/692 -> obin=1; 307/532, 508/693 -> obin=0; oen/obin one cycle after ien; oY equals inY delayed by 1 clk.
- Bounding box: frame where skin pixels occur only at (2,1),(5,1),(3,3) -> frame_done 2 clk after last pixel; x_min=2, x_max=5, y_min=1, y_max=3, pix_cnt=3, obj_found=1.
- Empty frame: no skin pixels -> frame_done pulse, bbox=0, pix_cnt=0, obj_found=0; previous results replaced.
- Abort: in_vs rising after 10 pixels, then full 32-pixel frame with 4 skin pixels -> exactly one frame_done, pix_cnt=4 (aborted pixels excluded).
- Bubbles and sync collision: random ien gaps across the frame -> results equal gap-free run; in_vs edge coincident with ien -> that pixel counted at (0,0).
